// File: rtl/main_memory_responder.sv
// Main-memory responder: fixed-latency pipelined vector loads plus same-cycle writes.
// Optional range checking is enabled by defining OOB_CHECK_EN.
module main_memory_responder #(
  parameter int WIDTH   = 512,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_ctrl,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [WIDTH-1:0]  load_data,
  output logic              load_valid,
  input  logic              write_ctrl,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [WIDTH-1:0]   r_dat [LATENCY];

  logic [IDX_W-1:0]   w_ld_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_ld_oob;
  logic               w_wr_oob;
  logic               w_wr_en;
  logic               w_fwd;
  logic [WIDTH-1:0]   w_rd_data;

  assign w_ld_idx = load_addr[IDX_W-1:0];
  assign w_wr_idx = write_addr[IDX_W-1:0];

`ifdef OOB_CHECK_EN
  logic r_wr_err;

  assign w_ld_oob = ({1'b0, load_addr}  >= (ADDR_W+1)'(DEPTH));
  assign w_wr_oob = ({1'b0, write_addr} >= (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_wr_err <= 1'b0;
    else          r_wr_err <= write_ctrl & w_wr_oob;
  end

  assign addr_err = (r_vld[LATENCY-1] & r_err[LATENCY-1]) | r_wr_err;
`else
  logic w_unused;

  // Upper address bits alias; they only matter when range checking is built in.
  assign w_ld_oob = 1'b0;
  assign w_wr_oob = 1'b0;
  assign w_unused = ^{1'b0, load_addr, write_addr, r_err};
  assign addr_err = 1'b0;
`endif

  // Write-first: a same-edge write to the loaded index bypasses the array.
  assign w_wr_en   = write_ctrl & ~w_wr_oob;
  assign w_fwd     = w_wr_en && (w_wr_idx == w_ld_idx);
  assign w_rd_data = w_ld_oob ? '0 : (w_fwd ? write_data : r_mem[w_ld_idx]);

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[w_wr_idx] <= write_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= load_ctrl;
      r_err[0] <= load_ctrl & w_ld_oob;
      if (load_ctrl) r_dat[0] <= w_rd_data;
      // Data stages only move with a valid entry, so the output holds between returns.
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign load_valid = r_vld[LATENCY-1];
  assign load_data  = r_dat[LATENCY-1];

endmodule
